// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcode values, instruction field positions
// and the default datapath geometry.
package id_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned CNTW_DEF = 16;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 26;
   localparam int unsigned RS_HI  = 25;
   localparam int unsigned RS_LO  = 21;
   localparam int unsigned RT_HI  = 20;
   localparam int unsigned RT_LO  = 16;
   localparam int unsigned RD_HI  = 15;
   localparam int unsigned RD_LO  = 11;
   localparam int unsigned IMM_HI = 15;
   localparam int unsigned FN_HI  = 5;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ALUI_LO = 6'h08;
   localparam logic [5:0] OP_ALUI_HI = 6'h0F;
   localparam logic [5:0] OP_LD_LO   = 6'h20;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LD_HI   = 6'h25;
   localparam logic [5:0] OP_ST_LO   = 6'h28;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] OP_ST_HI   = 6'h2B;

   typedef enum logic [1:0] {
      DST_NONE,
      DST_RD,
      DST_RT
   } dest_sel_e;

   function automatic dest_sel_e dest_sel(input logic [5:0] op);
      dest_sel_e sel;
      sel = DST_NONE;
      if (op == OP_RTYPE)
         sel = DST_RD;
      else if ((op >= OP_ALUI_LO && op <= OP_ALUI_HI) || (op >= OP_LD_LO && op <= OP_LD_HI))
         sel = DST_RT;
      return sel;
   endfunction

   function automatic logic rt_used(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
             (op >= OP_ST_LO && op <= OP_ST_HI);
   endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register, with a
// set port (issue), a clear port (writeback) and two combinational lookups.
module id_scoreboard
   import id_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_set,
   input  logic [AW-1:0] i_set_addr,
   input  logic          i_clr,
   input  logic [AW-1:0] i_clr_addr,
   input  logic [AW-1:0] i_rd_addr1,
   input  logic [AW-1:0] i_rd_addr2,
   output logic          o_busy1,
   output logic          o_busy2
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_next;

   // Set is applied after clear so the younger issuing instruction keeps the bit.
   always_comb begin
      w_busy_next = r_busy;
      if (i_clr && (i_clr_addr != '0))
         w_busy_next[i_clr_addr] = 1'b0;
      if (i_set && (i_set_addr != '0))
         w_busy_next[i_set_addr] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_next;
   end

   assign o_busy1 = r_busy[i_rd_addr1];
   assign o_busy2 = r_busy[i_rd_addr2];

endmodule

// File: rtl/id_scoreboard_stage.sv
// Decode stage: IF/ID holding register, MIPS field decode, busy-bit hazard stall and
// valid/ready issue into ID/EX, with a saturating hazard-stall counter.
module id_scoreboard_stage
   import id_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   output logic [AW-1:0]   readreg1,
   output logic [AW-1:0]   readreg2,
   output logic            id_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [5:0]      id_opcode,
   output logic [5:0]      id_funct,
   output logic [XLEN-1:0] id_imm,
   output logic [AW-1:0]   id_dest,
   output logic            id_regwrite,
   input  logic            flush,
   input  logic            wb_regwrite,
   input  logic [AW-1:0]   wb_writereg,
   output logic [CNTW-1:0] stall_cnt
);

   logic            r_hold_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;
   logic [CNTW-1:0] r_stall_cnt;

   logic [5:0]    w_opcode;
   logic [AW-1:0] w_rs;
   logic [AW-1:0] w_rt;
   logic [AW-1:0] w_rd;
   logic          w_rt_used;
   logic          w_busy_rs;
   logic          w_busy_rt;
   logic          w_hazard;
   logic          w_issue;

   assign w_opcode  = r_instr[OPC_HI:OPC_LO];
   assign w_rs      = r_instr[RS_HI:RS_LO];
   assign w_rt      = r_instr[RT_HI:RT_LO];
   assign w_rd      = r_instr[RD_HI:RD_LO];
   assign w_rt_used = rt_used(w_opcode);

   always_comb begin
      id_dest = '0;
      case (dest_sel(w_opcode))
         DST_RD:  id_dest = w_rd;
         DST_RT:  id_dest = w_rt;
         default: id_dest = '0;
      endcase
   end

   assign id_regwrite = (id_dest != '0);
   assign id_opcode   = w_opcode;
   assign id_funct    = r_instr[FN_HI:0];
   assign id_imm      = {{(XLEN-16){r_instr[IMM_HI]}}, r_instr[IMM_HI:0]};
   assign id_pc       = r_pc;
   assign readreg1    = w_rs;
   assign readreg2    = w_rt;

   id_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_set      (w_issue & id_regwrite),
      .i_set_addr (id_dest),
      .i_clr      (wb_regwrite),
      .i_clr_addr (wb_writereg),
      .i_rd_addr1 (w_rs),
      .i_rd_addr2 (w_rt),
      .o_busy1    (w_busy_rs),
      .o_busy2    (w_busy_rt)
   );

   assign w_hazard = r_hold_valid &
                     ((w_busy_rs & (w_rs != '0)) | (w_rt_used & w_busy_rt & (w_rt != '0)));
   assign id_valid = r_hold_valid & ~w_hazard & ~flush;
   assign w_issue  = id_valid & ex_ready;
   assign id_ready = ~r_hold_valid | w_issue | flush;

   // A load takes priority over the clear so issue/flush and refill happen in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold_valid <= 1'b0;
         r_instr      <= '0;
         r_pc         <= '0;
      end else if (if_valid && id_ready) begin
         r_hold_valid <= 1'b1;
         r_instr      <= if_instr;
         r_pc         <= if_pc;
      end else if (w_issue || flush) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (w_hazard && !flush && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNTW'(1);
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Directed bench for id_scoreboard_stage: a cycle-by-cycle vector table for the main
// decode/stall/issue flow plus hand-written multi-cycle corner sequences.
module tb_id_scoreboard_stage;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned CNTW = 4;

   localparam logic [31:0] I_ADD8  = 32'h012A4020; // add r8,r9,r10
   localparam logic [31:0] I_SUB11 = 32'h01095822; // sub r11,r8,r9
   localparam logic [31:0] I_LW3   = 32'h8C43FFF8; // lw r3,-8(r2)
   localparam logic [31:0] I_SW    = 32'hAC880000; // sw r8,0(r4)
   localparam logic [31:0] I_BEQ   = 32'h102B0003; // beq r1,r11,3
   localparam logic [31:0] I_ADDI  = 32'h200C0001; // addi r12,r0,1
   localparam logic [31:0] I_ORI   = 32'h34AC0007; // ori r12,r5,7
   localparam logic [31:0] I_J     = 32'h08000010; // j
   localparam logic [31:0] I_LW5   = 32'h8C250004; // lw r5,4(r1)
   localparam logic [31:0] I_ADD6  = 32'h00A03020; // add r6,r5,r0
   localparam logic [31:0] I_ADDI0 = 32'h20200005; // addi r0,r1,5
   localparam logic [31:0] I_ADD2  = 32'h00001020; // add r2,r0,r0

   logic            clk = 1'b0;
   logic            rst_n;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            id_ready;
   logic [AW-1:0]   readreg1;
   logic [AW-1:0]   readreg2;
   logic            id_valid;
   logic            ex_ready;
   logic [XLEN-1:0] id_pc;
   logic [5:0]      id_opcode;
   logic [5:0]      id_funct;
   logic [XLEN-1:0] id_imm;
   logic [AW-1:0]   id_dest;
   logic            id_regwrite;
   logic            flush;
   logic            wb_regwrite;
   logic [AW-1:0]   wb_writereg;
   logic [CNTW-1:0] stall_cnt;

   always #5 clk = ~clk;

   id_scoreboard_stage #(
      .XLEN (XLEN),
      .NREG (32),
      .AW   (AW),
      .CNTW (CNTW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready),
      .readreg1    (readreg1),
      .readreg2    (readreg2),
      .id_valid    (id_valid),
      .ex_ready    (ex_ready),
      .id_pc       (id_pc),
      .id_opcode   (id_opcode),
      .id_funct    (id_funct),
      .id_imm      (id_imm),
      .id_dest     (id_dest),
      .id_regwrite (id_regwrite),
      .flush       (flush),
      .wb_regwrite (wb_regwrite),
      .wb_writereg (wb_writereg),
      .stall_cnt   (stall_cnt)
   );

   typedef struct {
      logic        ifv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        exr;
      logic        wbw;
      logic [4:0]  wba;
      logic        dec;
      logic        e_valid;
      logic        e_ready;
      logic [4:0]  e_rr1;
      logic [4:0]  e_rr2;
      logic [4:0]  e_dest;
      logic        e_rw;
      logic [5:0]  e_op;
      logic [5:0]  e_fn;
      logic [31:0] e_imm;
      logic [31:0] e_pc;
      logic [3:0]  e_cnt;
      logic [31:0] e_busy;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(
      input logic ifv, input logic [31:0] instr, input logic [31:0] pc, input logic exr,
      input logic wbw, input logic [4:0] wba, input logic dec, input logic v, input logic r,
      input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] dest, input logic rw,
      input logic [5:0] op, input logic [5:0] fn, input logic [31:0] imm, input logic [31:0] epc,
      input logic [3:0] cnt, input logic [31:0] busy);
      vec_t t;
      t.ifv = ifv; t.instr = instr; t.pc = pc; t.exr = exr; t.wbw = wbw; t.wba = wba;
      t.dec = dec; t.e_valid = v; t.e_ready = r; t.e_rr1 = rr1; t.e_rr2 = rr2;
      t.e_dest = dest; t.e_rw = rw; t.e_op = op; t.e_fn = fn; t.e_imm = imm; t.e_pc = epc;
      t.e_cnt = cnt; t.e_busy = busy;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ifv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic exr, input logic fl, input logic wbw, input logic [4:0] wba);
      if_valid = ifv; if_instr = instr; if_pc = pc; ex_ready = exr;
      flush = fl; wb_regwrite = wbw; wb_writereg = wba;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] busy_vec();
      return dut.u_sb.r_busy;
   endfunction

   initial begin
      // inputs: ifv instr pc exr wbw wba | dec valid ready rr1 rr2 dest rw op fn imm pc cnt busy
      tbl.push_back(mk(1, I_ADD8,  32'h100, 1, 0, 0,  1, 0, 1, 0,  0,  0,  0, 6'h00, 6'h00, 32'h0,        32'h0,   0, 32'h0));
      tbl.push_back(mk(1, I_SUB11, 32'h104, 1, 0, 0,  1, 1, 1, 9,  10, 8,  1, 6'h00, 6'h20, 32'h4020,     32'h100, 0, 32'h0));
      tbl.push_back(mk(0, 0,       0,       1, 0, 0,  1, 0, 0, 8,  9,  11, 1, 6'h00, 6'h22, 32'h5822,     32'h104, 0, 32'h100));
      tbl.push_back(mk(0, 0,       0,       1, 0, 0,  1, 0, 0, 8,  9,  11, 1, 6'h00, 6'h22, 32'h5822,     32'h104, 1, 32'h100));
      tbl.push_back(mk(0, 0,       0,       1, 1, 8,  1, 0, 0, 8,  9,  11, 1, 6'h00, 6'h22, 32'h5822,     32'h104, 2, 32'h100));
      tbl.push_back(mk(1, I_LW3,   32'h108, 1, 0, 0,  1, 1, 1, 8,  9,  11, 1, 6'h00, 6'h22, 32'h5822,     32'h104, 3, 32'h0));
      for (int unsigned k = 0; k < 4; k++)
         tbl.push_back(mk(1, I_SW, 32'h10C, 0, 0, 0,  1, 1, 0, 2,  3,  3,  1, 6'h23, 6'h38, 32'hFFFFFFF8, 32'h108, 3, 32'h800));
      tbl.push_back(mk(1, I_SW,    32'h10C, 1, 0, 0,  1, 1, 1, 2,  3,  3,  1, 6'h23, 6'h38, 32'hFFFFFFF8, 32'h108, 3, 32'h800));
      tbl.push_back(mk(1, I_BEQ,   32'h110, 1, 0, 0,  1, 1, 1, 4,  8,  0,  0, 6'h2B, 6'h00, 32'h0,        32'h10C, 3, 32'h808));
      tbl.push_back(mk(0, 0,       0,       1, 1, 11, 1, 0, 0, 1,  11, 0,  0, 6'h04, 6'h03, 32'h3,        32'h110, 3, 32'h808));
      tbl.push_back(mk(0, 0,       0,       1, 1, 3,  1, 1, 1, 1,  11, 0,  0, 6'h04, 6'h03, 32'h3,        32'h110, 4, 32'h008));
      tbl.push_back(mk(1, I_ADDI,  32'h114, 1, 0, 0,  0, 0, 1, 0,  0,  0,  0, 6'h00, 6'h00, 32'h0,        32'h0,   4, 32'h0));
      tbl.push_back(mk(1, I_ORI,   32'h118, 1, 0, 0,  1, 1, 1, 0,  12, 12, 1, 6'h08, 6'h01, 32'h1,        32'h114, 4, 32'h0));
      tbl.push_back(mk(1, I_J,     32'h11C, 1, 0, 0,  1, 1, 1, 5,  12, 12, 1, 6'h0D, 6'h07, 32'h7,        32'h118, 4, 32'h1000));
      tbl.push_back(mk(0, 0,       0,       1, 1, 12, 1, 1, 1, 0,  0,  0,  0, 6'h02, 6'h10, 32'h10,       32'h11C, 4, 32'h1000));
      tbl.push_back(mk(0, 0,       0,       1, 0, 0,  0, 0, 1, 0,  0,  0,  0, 6'h00, 6'h00, 32'h0,        32'h0,   4, 32'h0));

      do_reset();
      for (int unsigned i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ifv, tbl[i].instr, tbl[i].pc, tbl[i].exr, 1'b0, tbl[i].wbw, tbl[i].wba);
         #3;
         chk($sformatf("v%0d.id_valid", i),  32'(id_valid),  32'(tbl[i].e_valid));
         chk($sformatf("v%0d.id_ready", i),  32'(id_ready),  32'(tbl[i].e_ready));
         chk($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
         chk($sformatf("v%0d.busy", i),      busy_vec(),     tbl[i].e_busy);
         if (tbl[i].dec) begin
            chk($sformatf("v%0d.readreg1", i),    32'(readreg1),    32'(tbl[i].e_rr1));
            chk($sformatf("v%0d.readreg2", i),    32'(readreg2),    32'(tbl[i].e_rr2));
            chk($sformatf("v%0d.id_dest", i),     32'(id_dest),     32'(tbl[i].e_dest));
            chk($sformatf("v%0d.id_regwrite", i), 32'(id_regwrite), 32'(tbl[i].e_rw));
            chk($sformatf("v%0d.id_opcode", i),   32'(id_opcode),   32'(tbl[i].e_op));
            chk($sformatf("v%0d.id_funct", i),    32'(id_funct),    32'(tbl[i].e_fn));
            chk($sformatf("v%0d.id_imm", i),      id_imm,           tbl[i].e_imm);
            chk($sformatf("v%0d.id_pc", i),       id_pc,            tbl[i].e_pc);
         end
         step();
      end

      // Set and clear of the same register in the issuing cycle: set wins
      do_reset();
      drive(1, I_LW5, 32'h200, 1, 0, 0, 0); #3; step();
      drive(0, 0, 0, 1, 0, 1, 5); #3;
      chk("setwin.id_valid", 32'(id_valid), 32'd1);
      chk("setwin.id_dest", 32'(id_dest), 32'd5);
      step();
      drive(1, I_ADD6, 32'h204, 1, 0, 0, 0); #3;
      chk("setwin.busy", busy_vec(), 32'h20);
      step();
      drive(0, 0, 0, 1, 0, 1, 5); #3;
      chk("setwin.stall_r5", 32'(id_valid), 32'd0);
      step();
      drive(0, 0, 0, 1, 0, 0, 0); #3;
      chk("setwin.release", 32'(id_valid), 32'd1);
      step();
      #3;
      chk("setwin.busy_r6", busy_vec(), 32'h40);

      // Flush of a stalled instruction together with a new fetch
      do_reset();
      drive(1, I_ADD8, 32'h300, 1, 0, 0, 0); #3; step();
      drive(1, I_SUB11, 32'h304, 1, 0, 0, 0); #3; step();
      drive(0, 0, 0, 1, 0, 0, 0); #3;
      chk("flush.pre_stall", 32'(id_valid), 32'd0);
      step();
      drive(1, I_ADD2, 32'h308, 0, 1, 0, 0); #3;
      chk("flush.id_valid", 32'(id_valid), 32'd0);
      chk("flush.id_ready", 32'(id_ready), 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0); #3;
      chk("flush.new_valid", 32'(id_valid), 32'd1);
      chk("flush.new_dest", 32'(id_dest), 32'd2);
      chk("flush.new_pc", id_pc, 32'h308);
      chk("flush.busy", busy_vec(), 32'h100);
      chk("flush.stall_cnt", 32'(stall_cnt), 32'd1);
      step();
      drive(0, 0, 0, 0, 1, 0, 0); #3;
      chk("flush2.id_ready", 32'(id_ready), 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0); #3;
      chk("flush2.id_valid", 32'(id_valid), 32'd0);
      chk("flush2.busy", busy_vec(), 32'h100);

      // Writes to r0 never mark busy; r0 sources never stall
      do_reset();
      drive(1, I_ADDI0, 32'h400, 1, 0, 0, 0); #3; step();
      drive(1, I_ADD2, 32'h404, 1, 0, 1, 0); #3;
      chk("r0.id_dest", 32'(id_dest), 32'd0);
      chk("r0.id_regwrite", 32'(id_regwrite), 32'd0);
      step();
      drive(0, 0, 0, 1, 0, 0, 0); #3;
      chk("r0.no_stall", 32'(id_valid), 32'd1);
      chk("r0.busy", busy_vec(), 32'h0);
      step();

      // Reset in the middle of a stall discards all pending state
      drive(1, I_ADD8, 32'h500, 1, 0, 0, 0); #3; step();
      drive(1, I_SUB11, 32'h504, 1, 0, 0, 0); #3; step();
      drive(0, 0, 0, 1, 0, 0, 0); #3;
      chk("rst.pre_stall", 32'(id_valid), 32'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0); #3;
      chk("rst.id_valid", 32'(id_valid), 32'd0);
      chk("rst.id_ready", 32'(id_ready), 32'd1);
      chk("rst.busy", busy_vec(), 32'h0);
      chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst.id_dest", 32'(id_dest), 32'd0);
      drive(1, I_SUB11, 32'h508, 1, 0, 0, 0); #3; step();
      drive(0, 0, 0, 1, 0, 0, 0); #3;
      chk("rst.sub_free", 32'(id_valid), 32'd1);
      step();

      // Stall counter saturation
      do_reset();
      drive(1, I_ADD8, 32'h600, 1, 0, 0, 0); #3; step();
      drive(1, I_SUB11, 32'h604, 1, 0, 0, 0); #3; step();
      drive(0, 0, 0, 1, 0, 0, 0);
      for (int unsigned k = 0; k < 15; k++) step();
      #3;
      chk("sat.at_max", 32'(stall_cnt), 32'hF);
      for (int unsigned k = 0; k < 5; k++) step();
      #3;
      chk("sat.held", 32'(stall_cnt), 32'hF);
      chk("sat.id_valid", 32'(id_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
